// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   uart_state_e         receiver FSM state encoding
//   DEFAULT_CLKS_PER_BIT divisor for 100 MHz (28 clocks per bit)
//   DATA_BITS            payload bits per frame
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 28;
  localparam int DATA_BITS            = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous bit.
// Parameter:
//   RESET_VAL  value both flops take on reset (so the output is defined at once)
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high
//   d_i    in   asynchronous input
//   q_o    out  d_i delayed by two clocks
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver, LSB first, CLKS_PER_BIT clocks per bit.
// Each good byte is presented on data_out with a one-cycle data_valid strobe.
// Build option: define UART_RX_PARITY_EN for 8E1 framing (even parity bit
// between the data bits and the stop bit); otherwise parity_err is tied 0.
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high
//   rxd          in   asynchronous serial input, idle high
//   data_out     out  last good byte received
//   data_valid   out  one-cycle strobe, data_out updated this cycle
//   frame_err    out  one-cycle strobe, stop bit sampled low
//   parity_err   out  one-cycle strobe, parity mismatch
//   busy         out  high whenever the FSM is not in IDLE
//   dbg_state_o  out  current FSM state
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rxd,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        frame_err,
  output logic        parity_err,
  output logic        busy,
  output uart_state_e dbg_state_o
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  logic                 rx_s;
  uart_state_e          state_q;
  logic [CW-1:0]        cnt_q;
  logic [2:0]           bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [7:0]           data_out_q;
  logic                 data_valid_q;
  logic                 frame_err_q;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q;
  logic                 parity_err_q;
`endif

  // Line idles high, so the synchroniser presets to 1 to avoid a false start.
  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rxd),
    .q_o   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      // Strobes are single-cycle; only the sampling branches below raise them.
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      cnt_q        <= cnt_q + CW'(1);

      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!rx_s) state_q <= START;
        end

        // Re-check the line at mid start bit; a short glitch goes back to IDLE.
        START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= rx_s ? IDLE : DATA;
          end
        end

        // Counting a full bit from mid start bit lands every sample mid-bit.
        DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q     <= '0;
            shift_q   <= {rx_s, shift_q[DATA_BITS-1:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        // Even parity: data bits plus parity bit must XOR to 0.
        PARITY: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q     <= '0;
            par_bad_q <= rx_s ^ (^shift_q);
            state_q   <= STOP;
          end
        end
`endif

        // Returning to IDLE at mid stop bit leaves half a bit to catch the
        // next start edge of a back-to-back frame.
        STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            if (rx_s) begin
              state_q <= IDLE;
`ifdef UART_RX_PARITY_EN
              if (par_bad_q) begin
                parity_err_q <= 1'b1;
              end else begin
                data_out_q   <= shift_q;
                data_valid_q <= 1'b1;
              end
`else
              data_out_q   <= shift_q;
              data_valid_q <= 1'b1;
`endif
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= BREAK;
            end
          end
        end

        // A line held low reports one frame error, then waits for idle.
        BREAK: begin
          cnt_q <= '0;
          if (rx_s) state_q <= IDLE;
        end

        default: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign frame_err   = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_q;
`else
  assign parity_err  = 1'b0;
`endif
  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule
